// File: rtl/reaction_controller.sv
// reaction_controller: sequencer for the reaction timer game.
// Generates a pseudo-random arm delay, lights the stimulus LED, then counts the
// reaction time in ms as 4 BCD digits, freezing on the press or flagging a foul.
// Optional best-time tracking is compiled in with `define REACTION_BEST_EN.
module reaction_controller #(
  parameter int         TICK_DIV  = 50000,
  parameter int         WAIT_MIN  = 1000,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic       cin,
  input  logic       rst,
  input  logic       start,
  input  logic       react,
  output logic       stim_led,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       done,
  output logic       foul,
  output logic       busy
`ifdef REACTION_BEST_EN
  ,
  output logic [3:0] best0,
  output logic [3:0] best1,
  output logic [3:0] best2,
  output logic [3:0] best3,
  output logic       new_best
`endif
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int N_DIG = 4;

  typedef enum logic [2:0] {IDLE, ARM, REACT, DONE, FOUL} state_t;

  state_t                       state;
  logic                         start_q, react_q;
  logic                         start_rise, react_rise;
  logic [7:0]                   lfsr;
  logic [PW-1:0]                cnt;
  logic                         tick;
  logic [12:0]                  delay;
  logic [12:0]                  delay_load;
  logic [N_DIG-1:0][3:0]        dig;
  logic [N_DIG-1:0][3:0]        dig_inc;
  logic                         carry;

  assign start_rise = start & ~start_q;
  assign react_rise = react & ~react_q;
  assign tick       = (cnt == PW'(TICK_DIV - 1));
  // WAIT_MIN <= 4095 plus an 8-bit LFSR value always fits in 13 bits
  assign delay_load = 13'(WAIT_MIN) + {5'd0, lfsr};

  assign bcd0 = dig[0];
  assign bcd1 = dig[1];
  assign bcd2 = dig[2];
  assign bcd3 = dig[3];

  // Previous-cycle copies of the buttons for rising-edge detection
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      react_q <= 1'b0;
    end else begin
      start_q <= start;
      react_q <= react;
    end
  end

  // Free-running Fibonacci LFSR, taps 8,6,5,4; a non-zero seed never reaches 0
  always_ff @(posedge cin or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Saturating BCD increment with ripple carry; 9999 stays 9999
  always_comb begin
    dig_inc = dig;
    carry   = 1'b1;
    if (dig != 16'h9999) begin
      for (int i = 0; i < N_DIG; i++) begin
        if (carry) begin
          if (dig[i] == 4'd9) begin
            dig_inc[i] = 4'd0;
          end else begin
            dig_inc[i] = dig[i] + 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  // Game FSM with registered status outputs; the prescaler restarts on every state entry
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      delay    <= '0;
      dig      <= '0;
      cnt      <= '0;
      stim_led <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      foul     <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + PW'(1);
      case (state)
        IDLE, DONE, FOUL: begin
          if (start_rise) begin
            state    <= ARM;
            delay    <= delay_load;
            dig      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            foul     <= 1'b0;
            stim_led <= 1'b0;
          end
        end
        ARM: begin
          // an early press wins over a tick landing in the same cycle
          if (react_rise) begin
            state <= FOUL;
            dig   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            foul  <= 1'b1;
          end else if (tick) begin
            if (delay == 13'd1) begin
              state    <= REACT;
              cnt      <= '0;
              stim_led <= 1'b1;
            end else begin
              delay <= delay - 13'd1;
            end
          end
        end
        REACT: begin
          // the press freezes the digits; a coincident tick is dropped
          if (react_rise) begin
            state    <= DONE;
            cnt      <= '0;
            stim_led <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (tick) begin
            dig <= dig_inc;
          end
        end
        default: begin
          state    <= IDLE;
          stim_led <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          foul     <= 1'b0;
        end
      endcase
    end
  end

`ifdef REACTION_BEST_EN
  logic [N_DIG-1:0][3:0] best;
  logic                  best_vld;

  assign best0 = best[0];
  assign best1 = best[1];
  assign best2 = best[2];
  assign best3 = best[3];

  // Best time captured on DONE entry; packed BCD compares MSD first like plain binary
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      best     <= '0;
      best_vld <= 1'b0;
      new_best <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (state == REACT && react_rise && (!best_vld || dig < best)) begin
        best     <= dig;
        best_vld <= 1'b1;
        new_best <= 1'b1;
      end
    end
  end
`endif

endmodule
